sys_cmd_host: RTL

- Host-side counterpart of the system controller: serialises RF-write, RF-read and ALU commands into UART byte frames and collects the response bytes.
- Sits between a test/host sequencer and a UART TX/RX pair, which connect to the system controller's UART.
- Used for loopback system verification and as a host bridge on the FPGA build.

---
 rtl/sys_cmd_pkg.sv | 53 +++++
 rtl/sys_cmd_tx_byte_hs.sv | 56 +++++
 rtl/sys_cmd_host.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sys_cmd_pkg.sv
// sys_cmd_pkg: shared definitions for the host-side command serialiser and
// the system-controller decoder that receives its frames.
//   - cmd_type encodings and the opcode byte that starts each frame
//   - FSM state encoding used by sys_cmd_host and sys_cmd_tx_byte_hs
//   - per-type frame length (bytes sent) and response length (bytes expected)
package sys_cmd_pkg;

    localparam logic [1:0] CMD_RF_WR   = 2'd0;
    localparam logic [1:0] CMD_RF_RD   = 2'd1;
    localparam logic [1:0] CMD_ALU_OP  = 2'd2;
    localparam logic [1:0] CMD_ALU_NOP = 2'd3;

    localparam logic [7:0] OPC_RF_WR   = 8'hAA;
    localparam logic [7:0] OPC_RF_RD   = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SEND    = 3'd1;
    localparam logic [2:0] ST_WAIT_BH = 3'd2;
    localparam logic [2:0] ST_WAIT_BL = 3'd3;
    localparam logic [2:0] ST_RSP     = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    function automatic logic [7:0] opcode(input logic [1:0] t);
        case (t)
            CMD_RF_WR:  opcode = OPC_RF_WR;
            CMD_RF_RD:  opcode = OPC_RF_RD;
            CMD_ALU_OP: opcode = OPC_ALU_OP;
            default:    opcode = OPC_ALU_NOP;
        endcase
    endfunction

    // Bytes on the wire, opcode included.
    function automatic logic [2:0] frame_len(input logic [1:0] t);
        case (t)
            CMD_RF_WR:  frame_len = 3'd3;
            CMD_RF_RD:  frame_len = 3'd2;
            CMD_ALU_OP: frame_len = 3'd4;
            default:    frame_len = 3'd2;
        endcase
    endfunction

    // Response bytes returned by the controller, LSB first.
    function automatic logic [1:0] rsp_len(input logic [1:0] t);
        case (t)
            CMD_RF_WR: rsp_len = 2'd0;
            CMD_RF_RD: rsp_len = 2'd1;
            default:   rsp_len = 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/sys_cmd_tx_byte_hs.sv
// sys_cmd_tx_byte_hs: busy-handshake byte sender in front of a UART TX.
// Walks SEND -> WAIT_BH -> WAIT_BL for each byte so a byte is strobed exactly
// once: it waits for busy to rise (TX took it) and then fall (TX finished).
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          begin a frame (byte 0 sent from SEND)
//   more           another byte follows the current one
//   byte_in        byte to send while in SEND
//   busy           UART TX busy
//   tx_p_data      byte to UART TX (held after the strobe)
//   tx_d_vld       one-cycle strobe
//   byte_done      current byte fully transmitted (WAIT_BL with busy low)
module sys_cmd_tx_byte_hs
    import sys_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  more,
    input  logic [DATA_WIDTH-1:0] byte_in,
    input  logic                  busy,
    output logic [DATA_WIDTH-1:0] tx_p_data,
    output logic                  tx_d_vld,
    output logic                  byte_done
);

    logic [2:0] phase;

    assign byte_done = (phase == ST_WAIT_BL) && !busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= ST_IDLE;
            tx_p_data <= '0;
            tx_d_vld  <= 1'b0;
        end else begin
            tx_d_vld <= 1'b0;
            case (phase)
                ST_IDLE:    if (start) phase <= ST_SEND;
                ST_SEND: begin
                    if (!busy) begin
                        tx_p_data <= byte_in;
                        tx_d_vld  <= 1'b1;
                        phase     <= ST_WAIT_BH;
                    end
                end
                ST_WAIT_BH: if (busy) phase <= ST_WAIT_BL;
                ST_WAIT_BL: if (!busy) phase <= more ? ST_SEND : ST_IDLE;
                default:    phase <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sys_cmd_host.sv
// sys_cmd_host: serialises RF-write / RF-read / ALU commands into UART byte
// frames and collects the controller's response bytes.
// Optional feature macro: SYS_CMD_HOST_TIMEOUT_EN (response timeout of
// TIMEOUT_CYC cycles; without it RSP waits indefinitely).
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (ready only in IDLE)
//   cmd_type/addr/wdata/op_a/op_b/fun  command fields, latched on accept
//   uart_tx_p_data/uart_tx_d_vld     byte + strobe to UART TX
//   uart_tx_busy                     UART TX busy
//   uart_rx_p_data/uart_rx_d_vld     byte + strobe from UART RX
//   rsp_data/rsp_valid/rsp_err       response word, completion and error pulses
module sys_cmd_host
    import sys_cmd_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int RF_ADDR     = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_type,
    input  logic [RF_ADDR-1:0]      cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH-1:0]   cmd_op_a,
    input  logic [DATA_WIDTH-1:0]   cmd_op_b,
    input  logic [3:0]              cmd_fun,
    output logic [DATA_WIDTH-1:0]   uart_tx_p_data,
    output logic                    uart_tx_d_vld,
    input  logic                    uart_tx_busy,
    input  logic [DATA_WIDTH-1:0]   uart_rx_p_data,
    input  logic                    uart_rx_d_vld,
    output logic [2*DATA_WIDTH-1:0] rsp_data,
    output logic                    rsp_valid,
    output logic                    rsp_err
);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    // ST_SEND here covers the whole byte-sender walk; the sender tracks
    // SEND/WAIT_BH/WAIT_BL itself.
    logic [2:0]            state;
    logic [1:0]            c_type;
    logic [RF_ADDR-1:0]    c_addr;
    logic [DATA_WIDTH-1:0] c_wdata, c_op_a, c_op_b;
    logic [3:0]            c_fun;
    logic [2:0]            idx;
    logic [1:0]            rx_cnt;
    logic [DATA_WIDTH-1:0] cur_byte;
    logic                  accept, more, byte_done, to_hit;

    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_DONE);
    assign accept    = cmd_valid && cmd_ready;
    assign more      = (idx + 3'd1) < frame_len(c_type);

    always_comb begin
        cur_byte = '0;
        case (idx)
            3'd0: cur_byte = DATA_WIDTH'(opcode(c_type));
            3'd1: begin
                case (c_type)
                    CMD_ALU_OP:  cur_byte = c_op_a;
                    CMD_ALU_NOP: cur_byte = DATA_WIDTH'(c_fun);
                    default:     cur_byte = DATA_WIDTH'(c_addr);
                endcase
            end
            3'd2:    cur_byte = (c_type == CMD_ALU_OP) ? c_op_b : c_wdata;
            3'd3:    cur_byte = DATA_WIDTH'(c_fun);
            default: cur_byte = '0;
        endcase
    end

    sys_cmd_tx_byte_hs #(.DATA_WIDTH(DATA_WIDTH)) u_tx_hs (
        .clk       (clk),
        .reset     (reset),
        .start     (accept),
        .more      (more),
        .byte_in   (cur_byte),
        .busy      (uart_tx_busy),
        .tx_p_data (uart_tx_p_data),
        .tx_d_vld  (uart_tx_d_vld),
        .byte_done (byte_done)
    );

`ifdef SYS_CMD_HOST_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_W-1:0] to_cnt;

    // Held at zero outside RSP, so it starts from zero on entry.
    always_ff @(posedge clk) begin
        if (reset || state != ST_RSP || uart_rx_d_vld) to_cnt <= '0;
        else                                           to_cnt <= to_cnt + 1'b1;
    end

    // An RX byte in the same cycle wins over the timeout.
    assign to_hit = (state == ST_RSP) && !uart_rx_d_vld &&
                    (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            c_type   <= '0;
            c_addr   <= '0;
            c_wdata  <= '0;
            c_op_a   <= '0;
            c_op_b   <= '0;
            c_fun    <= '0;
            idx      <= '0;
            rx_cnt   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            // Bytes outside RSP are dropped; a timeout reports alongside rsp_valid.
            rsp_err <= (uart_rx_d_vld && state != ST_RSP) || to_hit;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        c_type   <= cmd_type;
                        c_addr   <= cmd_addr;
                        c_wdata  <= cmd_wdata;
                        c_op_a   <= cmd_op_a;
                        c_op_b   <= cmd_op_b;
                        c_fun    <= cmd_fun;
                        idx      <= '0;
                        rx_cnt   <= '0;
                        rsp_data <= '0;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (byte_done) begin
                        idx <= idx + 3'd1;
                        if (!more)
                            state <= (rsp_len(c_type) != 2'd0) ? ST_RSP : ST_DONE;
                    end
                end
                ST_RSP: begin
                    if (uart_rx_d_vld) begin
                        if (rx_cnt == 2'd0) rsp_data[DATA_WIDTH-1:0]            <= uart_rx_p_data;
                        else                rsp_data[2*DATA_WIDTH-1:DATA_WIDTH] <= uart_rx_p_data;
                        rx_cnt <= rx_cnt + 2'd1;
                        if (rx_cnt + 2'd1 == rsp_len(c_type)) state <= ST_DONE;
                    end else if (to_hit) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
